// File: rtl/rr_logb_pkt_arbiter_if.sv
// rtl/rr_logb_pkt_arbiter_if.sv - request/output bundle of the round-robin packet arbiter
interface rr_logb_pkt_arbiter_if #(
    parameter int N_CH       = 4,
    parameter int DATA_WIDTH = 512
);
    localparam int ID_W = $clog2(N_CH);

    logic [N_CH-1:0]            req_valid;
    logic [N_CH*DATA_WIDTH-1:0] req_data;
    logic [N_CH-1:0]            req_last;
    logic [N_CH-1:0]            req_ready;
    logic                       out_valid;
    logic                       out_ready;
    logic [DATA_WIDTH-1:0]      out_data;
    logic                       out_last;
    logic [ID_W-1:0]            out_id;
    logic                       err_timeout;

    // Environment side: drives channel beats and downstream ready
    modport master (
        output req_valid, req_data, req_last, out_ready,
        input  req_ready, out_valid, out_data, out_last, out_id, err_timeout
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_data, req_last, out_ready,
        output req_ready, out_valid, out_data, out_last, out_id, err_timeout
    );
endinterface

// File: rtl/rr_logb_pkt_arbiter.sv
// rtl/rr_logb_pkt_arbiter.sv - round-robin packet-locked arbiter, optional lock timeout via RR_ARB_TIMEOUT_EN
module rr_logb_pkt_arbiter #(
    parameter int N_CH       = 4,
    parameter int DATA_WIDTH = 512,
    parameter int TIMEOUT    = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rr_logb_pkt_arbiter_if.slave  bus
);
    localparam int ID_W = $clog2(N_CH);

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t                 state_q;
    logic [ID_W-1:0]        ptr_q;
    logic [ID_W-1:0]        owner_q;
    logic                   out_valid_q;
    logic [DATA_WIDTH-1:0]  out_data_q;
    logic                   out_last_q;
    logic [ID_W-1:0]        out_id_q;

`ifdef RR_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]       tmo_cnt_q;
    logic                   err_q;
`endif

    logic                   load_en;
    logic                   win_found;
    logic [ID_W-1:0]        win_idx;
    logic [ID_W-1:0]        grant_idx;
    logic [N_CH-1:0]        ready_d;
    logic                   accept;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic                   sel_last;
    int                     cand;

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        if (id == ID_W'(N_CH - 1)) begin
            return '0;
        end
        return id + 1'b1;
    endfunction

    // Grant selection: search upward from ptr in IDLE, stick to the owner while LOCKED
    always_comb begin
        load_en   = !out_valid_q || bus.out_ready;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int k = 0; k < N_CH; k++) begin
            cand = (int'(ptr_q) + k) % N_CH;
            if (!win_found && bus.req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = ID_W'(cand);
            end
        end
        grant_idx = (state_q == LOCKED) ? owner_q : win_idx;
        ready_d   = '0;
        if (rst_n) begin
            if (state_q == LOCKED) begin
                ready_d[owner_q] = load_en;
            end else if (win_found) begin
                ready_d[win_idx] = load_en;
            end
        end
        accept   = |(ready_d & bus.req_valid);
        sel_data = bus.req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        sel_last = bus.req_last[grant_idx];
    end

    // Output register, lock FSM, round-robin pointer and lock watchdog
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_id_q    <= '0;
`ifdef RR_ARB_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            if (load_en) begin
                out_valid_q <= accept;
                if (accept) begin
                    out_data_q <= sel_data;
                    out_last_q <= sel_last;
                    out_id_q   <= grant_idx;
                end
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (sel_last) begin
                            ptr_q <= next_id(win_idx);
                        end else begin
                            state_q <= LOCKED;
                            owner_q <= win_idx;
`ifdef RR_ARB_TIMEOUT_EN
                            tmo_cnt_q <= '0;
`endif
                        end
                    end
                end
                LOCKED: begin
                    if (accept) begin
`ifdef RR_ARB_TIMEOUT_EN
                        tmo_cnt_q <= '0;
`endif
                        // The closing beat only releases the lock; the next grant is decided next cycle
                        if (sel_last) begin
                            state_q <= IDLE;
                            ptr_q   <= next_id(owner_q);
                        end
                    end
`ifdef RR_ARB_TIMEOUT_EN
                    else if (!bus.req_valid[owner_q]) begin
                        // Owner went silent mid-packet: drop the lock without inventing a last beat
                        if (tmo_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                            state_q   <= IDLE;
                            ptr_q     <= next_id(owner_q);
                            err_q     <= 1'b1;
                            tmo_cnt_q <= '0;
                        end else begin
                            tmo_cnt_q <= tmo_cnt_q + 1'b1;
                        end
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = ready_d;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_id    = out_id_q;
`ifdef RR_ARB_TIMEOUT_EN
    assign bus.err_timeout = err_q;
`else
    assign bus.err_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_rr_logb_pkt_arbiter.sv
// tb/tb_rr_logb_pkt_arbiter.sv - directed self-checking bench for rr_logb_pkt_arbiter
module tb_rr_logb_pkt_arbiter;
    localparam int N   = 4;
    localparam int DW  = 16;
    localparam int TMO = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errs   = 0;

    always #5 clk = ~clk;

    rr_logb_pkt_arbiter_if #(.N_CH(N), .DATA_WIDTH(DW)) bus ();

    rr_logb_pkt_arbiter #(.N_CH(N), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input int ch, input logic v, input logic l, input logic [DW-1:0] d);
        bus.req_valid[ch]          = v;
        bus.req_last[ch]           = l;
        bus.req_data[ch*DW +: DW]  = d;
    endtask

    task automatic clear_all();
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        clear_all();
        bus.out_ready = 1'b1;
        bus.req_valid = 4'b1111;

        // Reset state
        #3;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_id", bus.out_id, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_err", bus.err_timeout, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        tick();
        tick();
        clear_all();
        rst_n = 1'b1;
        tick();

        // ch1 and ch3 one-beat packets every cycle alternate 1,3,1,3
        drv(1, 1, 1, 16'h0011);
        drv(3, 1, 1, 16'h0033);
        settle();
        chk("alt_rdy0", bus.req_ready, 4'b0010);
        tick();
        chk("alt_v0", bus.out_valid, 1);
        chk("alt_id0", bus.out_id, 1);
        chk("alt_d0", bus.out_data, 16'h0011);
        chk("alt_rdy1", bus.req_ready, 4'b1000);
        tick();
        chk("alt_id1", bus.out_id, 3);
        chk("alt_d1", bus.out_data, 16'h0033);
        tick();
        chk("alt_id2", bus.out_id, 1);
        chk("alt_v2", bus.out_valid, 1);
        tick();
        chk("alt_id3", bus.out_id, 3);
        clear_all();
        tick();
        chk("alt_drain", bus.out_valid, 0);

        // ch0 three-beat packet blocks ch2 until its last beat
        drv(0, 1, 0, 16'h00A0);
        drv(2, 1, 1, 16'h0022);
        settle();
        chk("pkt_rdy0", bus.req_ready, 4'b0001);
        tick();
        chk("pkt_d0", bus.out_data, 16'h00A0);
        chk("pkt_id0", bus.out_id, 0);
        chk("pkt_l0", bus.out_last, 0);
        drv(0, 1, 0, 16'h00A1);
        settle();
        chk("pkt_rdy1", bus.req_ready, 4'b0001);
        tick();
        chk("pkt_d1", bus.out_data, 16'h00A1);
        chk("pkt_id1", bus.out_id, 0);
        drv(0, 1, 1, 16'h00A2);
        settle();
        chk("pkt_rdy2", bus.req_ready, 4'b0001);
        tick();
        chk("pkt_d2", bus.out_data, 16'h00A2);
        chk("pkt_l2", bus.out_last, 1);
        drv(0, 0, 0, 16'h0000);
        settle();
        chk("pkt_rdy3", bus.req_ready, 4'b0100);
        tick();
        chk("pkt_id3", bus.out_id, 2);
        chk("pkt_d3", bus.out_data, 16'h0022);
        clear_all();
        tick();
        chk("pkt_drain", bus.out_valid, 0);

        // Backpressure: output held, no request accepted, then next beat resumes
        drv(1, 1, 1, 16'h0051);
        settle();
        chk("bp_rdy0", bus.req_ready, 4'b0010);
        tick();
        chk("bp_d0", bus.out_data, 16'h0051);
        bus.out_ready = 1'b0;
        drv(1, 1, 1, 16'h0052);
        settle();
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_rdy", bus.req_ready, 4'b0000);
            tick();
            chk("bp_hold_data", bus.out_data, 16'h0051);
            chk("bp_hold_valid", bus.out_valid, 1);
        end
        bus.out_ready = 1'b1;
        settle();
        chk("bp_rel_rdy", bus.req_ready, 4'b0010);
        tick();
        chk("bp_rel_data", bus.out_data, 16'h0052);
        chk("bp_rel_id", bus.out_id, 1);
        clear_all();
        tick();
        chk("bp_drain", bus.out_valid, 0);

        // Pointer wrap: ch2 moves ptr to 3, then ch3 wins and ch0 follows
        drv(2, 1, 1, 16'h0222);
        tick();
        chk("wrap_id2", bus.out_id, 2);
        for (int c = 0; c < N; c++) drv(c, 1, 1, DW'(16'h0300 + c));
        settle();
        chk("wrap_rdy3", bus.req_ready, 4'b1000);
        tick();
        chk("wrap_id3", bus.out_id, 3);
        chk("wrap_rdy0", bus.req_ready, 4'b0001);
        tick();
        chk("wrap_id0", bus.out_id, 0);
        chk("wrap_d0", bus.out_data, 16'h0300);
        clear_all();
        tick();

        // ch2 locks then goes silent; ptr is 1 so ch2 wins
        drv(2, 1, 0, 16'h0B20);
        tick();
        chk("lock_id", bus.out_id, 2);
        drv(2, 0, 0, 16'h0000);
        drv(3, 1, 1, 16'h0B30);
        settle();
        chk("lock_rdy", bus.req_ready, 4'b0100);
        for (int i = 0; i < TMO - 1; i++) tick();
        chk("lock_err_pre", bus.err_timeout, 0);
        chk("lock_rdy_pre", bus.req_ready, 4'b0100);
        tick();
`ifdef RR_ARB_TIMEOUT_EN
        chk("tmo_err", bus.err_timeout, 1);
        chk("tmo_rdy", bus.req_ready, 4'b1000);
        tick();
        chk("tmo_id", bus.out_id, 3);
        chk("tmo_data", bus.out_data, 16'h0B30);
        chk("tmo_sticky", bus.err_timeout, 1);
`else
        chk("hold_err", bus.err_timeout, 0);
        chk("hold_rdy", bus.req_ready, 4'b0100);
        tick();
        chk("hold_rdy2", bus.req_ready, 4'b0100);
        drv(2, 1, 1, 16'h0B21);
        tick();
        chk("hold_id", bus.out_id, 2);
        chk("hold_last", bus.out_last, 1);
        chk("hold_rdy3", bus.req_ready, 4'b1000);
        drv(2, 0, 0, 16'h0000);
        tick();
        chk("hold_id3", bus.out_id, 3);
`endif
        clear_all();
        tick();

        // Reset during beat 2 of a 4-beat ch1 packet
        drv(1, 1, 0, 16'h0061);
        tick();
        chk("mr_d0", bus.out_data, 16'h0061);
        drv(1, 1, 0, 16'h0062);
        tick();
        chk("mr_d1", bus.out_data, 16'h0062);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_valid", bus.out_valid, 0);
        chk("mr_data", bus.out_data, 0);
        chk("mr_id", bus.out_id, 0);
        chk("mr_rdy", bus.req_ready, 0);
        chk("mr_err", bus.err_timeout, 0);
        drv(0, 1, 1, 16'h0070);
        drv(1, 1, 0, 16'h0063);
        #1;
        rst_n = 1'b1;
        #1;
        chk("mr_rdy_rel", bus.req_ready, 4'b0001);
        tick();
        chk("mr_id_rel", bus.out_id, 0);
        chk("mr_d_rel", bus.out_data, 16'h0070);
        clear_all();
        tick();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
